fp_mant_normalize_seq: RTL and testbench

- Multi-cycle normaliser for the float32 add/sub datapath. Sits directly downstream of the 24-bit two's-complement / mantissa adder stage.
- Accepts the raw magnitude sum plus its carry-out, the result sign and the larger operand's biased exponent.
- Shifts the mantissa until the hidden bit is set, or until the denormal range is reached, and adjusts the exponent to match.
- Emits the IEEE-754 fraction, exponent and status flags over a valid/ready handshake to the rounding/pack stage.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_norm_shift_step.sv | 37 +++
 rtl/fp_mant_normalize_seq.sv | 149 ++++++++++++++
 tb/tb_fp_mant_normalize_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the float32 add/sub normaliser:
// FP32 field widths, FSM state encoding and the result status flags.
package fp_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;
  localparam int EXP_INF  = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic ovf;
  } norm_flags_t;

endpackage

// File: rtl/fp_norm_shift_step.sv
// One normalisation step: left-shifts the mantissa towards the hidden bit
// and lowers the exponent to match, stopping at the hidden bit or at the
// denormal floor (exponent 1).
// Optional macro FP_NORM_FAST_SHIFT_EN enables a 4-bit step when the top
// nibble is clear and the exponent has room for it.
module fp_norm_shift_step #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [MANT_W-1:0] mant_next,
  output logic [EXP_W-1:0]  exp_next,
  output logic              done
);

  // Decide whether normalisation is finished, otherwise take one step
  always_comb begin
    mant_next = mant_in;
    exp_next  = exp_in;
    done      = 1'b0;
    if (mant_in[MANT_W-1] || (exp_in <= EXP_W'(1))) begin
      done = 1'b1;
    end
`ifdef FP_NORM_FAST_SHIFT_EN
    else if ((mant_in[MANT_W-1 -: 4] == 4'b0000) && (exp_in > EXP_W'(4))) begin
      mant_next = mant_in << 4;
      exp_next  = exp_in - EXP_W'(4);
    end
`endif
    else begin
      mant_next = mant_in << 1;
      exp_next  = exp_in - EXP_W'(1);
    end
  end

endmodule

// File: rtl/fp_mant_normalize_seq.sv
// Multi-cycle mantissa normaliser for the float32 add/sub datapath.
// Takes the adder's magnitude sum (with carry-out), sign and larger
// exponent, normalises over one or more cycles and presents the fraction,
// exponent and status flags on a valid/ready handshake.
// Optional macro FP_NORM_FAST_SHIFT_EN (in fp_norm_shift_step) speeds up
// long left shifts without changing results.
module fp_mant_normalize_seq
  import fp_pkg::*;
#(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MANT_W:0]    in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MANT_W-2:0]  out_frac,
  output logic               out_sticky,
  output logic               out_zero,
  output logic               out_denorm,
  output logic               out_ovf
);

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = {EXP_W{1'b1}};

  norm_state_t       state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              sticky_q, sticky_d;
  norm_flags_t       flags_q, flags_d;

  logic [EXP_W-1:0]  exp_eff;
  logic [EXP_W-1:0]  exp_inc;
  logic [MANT_W-1:0] step_mant;
  logic [EXP_W-1:0]  step_exp;
  logic              step_done;

  // A zero exponent behaves as 1 so denormal inputs share the normal path
  assign exp_eff = (in_exp == '0) ? EXP_W'(1) : in_exp;
  assign exp_inc = exp_eff + EXP_W'(1);

  fp_norm_shift_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_step (
    .mant_in   (mant_q),
    .exp_in    (exp_q),
    .mant_next (step_mant),
    .exp_next  (step_exp),
    .done      (step_done)
  );

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          sticky_d = 1'b0;
          flags_d  = '0;
          exp_d    = exp_eff;
          mant_d   = in_mant[MANT_W-1:0];
          if (in_mant == '0) begin
            mant_d       = '0;
            exp_d        = '0;
            sign_d       = 1'b0;
            flags_d.zero = 1'b1;
            state_d      = DONE;
          end else if (in_mant[MANT_W]) begin
            mant_d   = in_mant[MANT_W:1];
            exp_d    = exp_inc;
            sticky_d = in_mant[0];
            if (exp_inc == EXP_ALL_ONES) begin
              mant_d      = {1'b1, {(MANT_W-1){1'b0}}};
              flags_d.ovf = 1'b1;
            end
            state_d = DONE;
          end else if (in_mant[MANT_W-1]) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (step_done) begin
          state_d = DONE;
          if (!mant_q[MANT_W-1]) begin
            exp_d          = '0;
            flags_d.denorm = 1'b1;
          end
        end else begin
          mant_d = step_mant;
          exp_d  = step_exp;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_sign   = sign_q;
  assign out_exp    = exp_q;
  assign out_frac   = mant_q[MANT_W-2:0];
  assign out_sticky = sticky_q;
  assign out_zero   = flags_q.zero;
  assign out_denorm = flags_q.denorm;
  assign out_ovf    = flags_q.ovf;

endmodule

// File: tb/tb_fp_mant_normalize_seq.sv
// Self-checking bench for fp_mant_normalize_seq: directed cases plus
// randomized words compared against a leading-one based reference model.
module tb_fp_mant_normalize_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_sticky;
  logic        out_zero;
  logic        out_denorm;
  logic        out_ovf;

  int compared;
  int mismatched;

  logic        e_sign;
  logic [7:0]  e_exp;
  logic [22:0] e_frac;
  logic        e_sticky;
  logic        e_zero;
  logic        e_denorm;
  logic        e_ovf;
  int          e_lat;
  int          lat;

  fp_mant_normalize_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_frac   (out_frac),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, expv);
    end
  endtask

  // Reference: position of the leading one decides how far to shift,
  // the exponent headroom decides whether the result ends up denormal.
  task automatic modelCompute(input logic s, input logic [7:0] e, input logic [24:0] m);
    int ee, lead, need, avail, k, steps;
    logic [23:0] mm;
    ee = (e == 8'd0) ? 1 : int'(e);
    e_sign = s; e_sticky = 1'b0; e_zero = 1'b0; e_denorm = 1'b0; e_ovf = 1'b0;
    e_lat = 1;
    if (m == 25'd0) begin
      e_zero = 1'b1; e_exp = 8'd0; e_frac = 23'd0; e_sign = 1'b0;
    end else if (m[24]) begin
      e_exp = 8'(ee + 1);
      e_sticky = m[0];
      if (ee + 1 == 255) begin
        e_ovf = 1'b1; e_frac = 23'd0;
      end else begin
        e_frac = m[23:1];
      end
    end else begin
      lead = 0;
      for (int i = 0; i < 24; i++) if (m[i]) lead = i;
      need  = 23 - lead;
      avail = ee - 1;
      k = (need < avail) ? need : avail;
      mm = m[23:0] << k;
      e_frac = mm[22:0];
      if (need <= avail) e_exp = 8'(ee - need);
      else begin
        e_exp = 8'd0; e_denorm = 1'b1;
      end
      steps = k;
`ifdef FP_NORM_FAST_SHIFT_EN
      begin
        int pos, cur;
        pos = lead; cur = ee; steps = 0;
        while (pos < 23 && cur > 1) begin
          if (pos <= 19 && cur > 4) begin pos += 4; cur -= 4; end
          else begin pos += 1; cur -= 1; end
          steps++;
        end
      end
`endif
      e_lat = 1 + steps;
    end
  endtask

  // Offer one word, then count cycles from the accept edge to out_valid
  task automatic applyStimulus(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m);
    @(negedge clk);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat <= 60) begin
      if (lat > 0 && out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(e_lat));
    checkOutput({tag, ".sign"},    32'(out_sign), 32'(e_sign));
    checkOutput({tag, ".exp"},     32'(out_exp), 32'(e_exp));
    checkOutput({tag, ".frac"},    32'(out_frac), 32'(e_frac));
    checkOutput({tag, ".sticky"},  32'(out_sticky), 32'(e_sticky));
    checkOutput({tag, ".zero"},    32'(out_zero), 32'(e_zero));
    checkOutput({tag, ".denorm"},  32'(out_denorm), 32'(e_denorm));
    checkOutput({tag, ".ovf"},     32'(out_ovf), 32'(e_ovf));
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m);
    modelCompute(s, e, m);
    applyStimulus(tag, s, e, m);
    checkResult(tag);
    releaseOutput();
  endtask

  initial begin
    int seen;
    logic [24:0] rm;
    logic [7:0]  re;
    int pos, cls;
    compared = 0; mismatched = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 25'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.in_ready",  32'(in_ready), 32'd1);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.exp",       32'(out_exp), 32'd0);
    checkOutput("reset.frac",      32'(out_frac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    runCase("normal",   1'b1, 8'd127, 25'h0800000);
    checkOutput("normal.exp_const", 32'(out_exp), 32'd127);
    runCase("carry",    1'b0, 8'd127, 25'h1000001);
    runCase("carryovf", 1'b0, 8'd254, 25'h1000001);
    runCase("longshift", 1'b0, 8'd127, 25'h0000001);
`ifdef FP_NORM_FAST_SHIFT_EN
    checkOutput("longshift.lat_const", 32'(lat), 32'd9);
`else
    checkOutput("longshift.lat_const", 32'(lat), 32'd24);
`endif
    runCase("denorm",   1'b0, 8'd5, 25'h0000100);
    checkOutput("denorm.frac_const", 32'(out_frac), 32'h001000);

    // Zero result, then hold out_ready low and watch the outputs stay put
    modelCompute(1'b1, 8'd90, 25'd0);
    applyStimulus("zero", 1'b1, 8'd90, 25'd0);
    checkResult("zero");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold.in_ready",  32'(in_ready), 32'd0);
      checkOutput("hold.zero",      32'(out_zero), 32'd1);
      checkOutput("hold.exp",       32'(out_exp), 32'd0);
    end
    releaseOutput();

    // Reset in the middle of a long shift: the word must vanish
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 25'h0000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset.in_ready",  32'(in_ready), 32'd1);
    checkOutput("midreset.frac",      32'(out_frac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("midreset.no_output", 32'(seen), 32'd0);
    runCase("afterreset", 1'b1, 8'd127, 25'h0800000);

    // Randomized words across all mantissa shapes and exponent ranges
    for (int n = 0; n < 200; n++) begin
      cls = int'($urandom_range(0, 9));
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 25)) : 8'($urandom_range(0, 254));
      if (cls == 0) rm = 25'd0;
      else if (cls <= 2) rm = {1'b1, 24'($urandom)};
      else begin
        pos = int'($urandom_range(0, 23));
        rm = (25'($urandom) & ((25'd1 << pos) - 25'd1)) | (25'd1 << pos);
      end
      runCase("rand", 1'($urandom), re, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
